// File: rtl/ama_riscv_pkg.sv
// Shared AMA-RISCV constants and types: write-back source select, load funct3 codes,
// and the MEM/WB stage bundle.
package ama_riscv_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned RF_ADDR_W = 5;

  typedef enum logic [1:0] {
    WB_SEL_MEM = 2'd0,
    WB_SEL_ALU = 2'd1,
    WB_SEL_PC4 = 2'd2,
    WB_SEL_CSR = 2'd3
  } wb_sel_e;

  localparam logic [2:0] LD_B  = 3'd0;
  localparam logic [2:0] LD_H  = 3'd1;
  localparam logic [2:0] LD_W  = 3'd2;
  localparam logic [2:0] LD_BU = 3'd4;
  localparam logic [2:0] LD_HU = 3'd5;

  typedef struct packed {
    logic                 valid;
    logic                 rd_we;
    logic [RF_ADDR_W-1:0] rd_addr;
    wb_sel_e              wb_sel;
    logic [2:0]           funct3;
    logic [XLEN-1:0]      alu_out;
    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      csr_data;
  } wb_stage_t;

endpackage

// File: rtl/ama_riscv_load_align.sv
// Load data alignment: selects the byte/halfword addressed by the low address bits of a
// synchronous-memory read word and sign- or zero-extends it according to funct3.
module ama_riscv_load_align
  import ama_riscv_pkg::*;
(
  input  logic [XLEN-1:0] dmem_rdata_i,
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      offset_i,
  output logic [XLEN-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = dmem_rdata_i[7:0];
    case (offset_i)
      2'd0:    byte_sel = dmem_rdata_i[7:0];
      2'd1:    byte_sel = dmem_rdata_i[15:8];
      2'd2:    byte_sel = dmem_rdata_i[23:16];
      default: byte_sel = dmem_rdata_i[31:24];
    endcase
    // Misaligned halfword offsets fall back to the containing aligned halfword.
    half_sel = offset_i[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
  end

  always_comb begin
    data_o = dmem_rdata_i;
    case (funct3_i)
      LD_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
      LD_BU:   data_o = {24'd0, byte_sel};
      LD_H:    data_o = {{16{half_sel[15]}}, half_sel};
      LD_HU:   data_o = {16'd0, half_sel};
      LD_W:    data_o = dmem_rdata_i;
      default: data_o = dmem_rdata_i;
    endcase
  end

endmodule

// File: rtl/ama_riscv_writeback.sv
// AMA-RISCV write-back stage: MEM/WB register, load alignment, source mux, rf write port
// and decode bypass flags. Optional retired-instruction counter: AMA_RISCV_WB_INSTRET_EN.
module ama_riscv_writeback
  import ama_riscv_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic                 in_rd_we,
  input  logic [RF_ADDR_W-1:0] in_rd_addr,
  input  logic [1:0]           in_wb_sel,
  input  logic [2:0]           in_funct3,
  input  logic [XLEN-1:0]      in_alu_out,
  input  logic [XLEN-1:0]      in_pc,
  input  logic [XLEN-1:0]      in_csr_data,
  input  logic [XLEN-1:0]      dmem_rdata,
  input  logic [RF_ADDR_W-1:0] dec_rs1,
  input  logic [RF_ADDR_W-1:0] dec_rs2,
  output logic                 rf_we,
  output logic [RF_ADDR_W-1:0] rf_addr_d,
  output logic [XLEN-1:0]      rf_data_d,
  output logic                 fwd_a,
  output logic                 fwd_b,
  output logic                 wb_valid,
  output logic [63:0]          instret
);

  wb_stage_t       stage_q, stage_d;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] wb_data;

  always_comb begin
    stage_d = stage_q;
    if (flush) begin
      stage_d.valid = 1'b0;
    end else if (!stall) begin
      stage_d = '{valid:    in_valid,
                  rd_we:    in_rd_we,
                  rd_addr:  in_rd_addr,
                  wb_sel:   wb_sel_e'(in_wb_sel),
                  funct3:   in_funct3,
                  alu_out:  in_alu_out,
                  pc:       in_pc,
                  csr_data: in_csr_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  ama_riscv_load_align u_load_align (
    .dmem_rdata_i (dmem_rdata),
    .funct3_i     (stage_q.funct3),
    .offset_i     (stage_q.alu_out[1:0]),
    .data_o       (load_data)
  );

  always_comb begin
    wb_data = '0;
    unique case (stage_q.wb_sel)
      WB_SEL_MEM: wb_data = load_data;
      WB_SEL_ALU: wb_data = stage_q.alu_out;
      WB_SEL_PC4: wb_data = stage_q.pc + 32'd4;
      WB_SEL_CSR: wb_data = stage_q.csr_data;
    endcase
  end

  // Stall suppresses the write so a held instruction commits exactly once, on release.
  assign rf_we     = stage_q.valid & stage_q.rd_we & (stage_q.rd_addr != '0) & ~stall;
  assign rf_addr_d = stage_q.rd_addr;
  // Zero when empty so the port does not follow dmem_rdata while idle or in reset.
  assign rf_data_d = stage_q.valid ? wb_data : '0;
  assign fwd_a     = rf_we & (dec_rs1 == stage_q.rd_addr);
  assign fwd_b     = rf_we & (dec_rs2 == stage_q.rd_addr);
  assign wb_valid  = stage_q.valid;

`ifdef AMA_RISCV_WB_INSTRET_EN
  logic        retire;
  logic [63:0] instret_q, instret_d;

  assign retire    = stage_q.valid & ~stall;
  assign instret_d = instret_q + {63'd0, retire};

  always_ff @(posedge clk) begin
    if (rst) begin
      instret_q <= '0;
    end else begin
      instret_q <= instret_d;
    end
  end

  assign instret = instret_q;
`else
  assign instret = 64'd0;
`endif

endmodule

// File: tb/tb_ama_riscv_writeback.sv
// Bench for ama_riscv_writeback: directed vectors with literal expectations plus a
// behavioural model compared against the DUT every cycle.
module tb_ama_riscv_writeback;

  logic        clk, rst, stall, flush;
  logic        in_valid, in_rd_we;
  logic [4:0]  in_rd_addr;
  logic [1:0]  in_wb_sel;
  logic [2:0]  in_funct3;
  logic [31:0] in_alu_out, in_pc, in_csr_data, dmem_rdata;
  logic [4:0]  dec_rs1, dec_rs2;
  logic        rf_we, fwd_a, fwd_b, wb_valid;
  logic [4:0]  rf_addr_d;
  logic [31:0] rf_data_d;
  logic [63:0] instret;

  int checks = 0;
  int failures = 0;

  ama_riscv_writeback dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_rd_we    (in_rd_we),
    .in_rd_addr  (in_rd_addr),
    .in_wb_sel   (in_wb_sel),
    .in_funct3   (in_funct3),
    .in_alu_out  (in_alu_out),
    .in_pc       (in_pc),
    .in_csr_data (in_csr_data),
    .dmem_rdata  (dmem_rdata),
    .dec_rs1     (dec_rs1),
    .dec_rs2     (dec_rs2),
    .rf_we       (rf_we),
    .rf_addr_d   (rf_addr_d),
    .rf_data_d   (rf_data_d),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b),
    .wb_valid    (wb_valid),
    .instret     (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model state: what the stage holds after each edge.
  logic            m_valid = 0, m_we = 0;
  logic [4:0]      m_rd = 0;
  logic [1:0]      m_sel = 0;
  logic [2:0]      m_f3 = 0;
  logic [31:0]     m_alu = 0, m_pc = 0, m_csr = 0;
  longint unsigned m_instret = 0;

  function automatic logic [31:0] m_load(input logic [31:0] w, input logic [2:0] f3,
                                         input logic [1:0] off);
    logic [31:0] v;
    if (f3 == 3'd0 || f3 == 3'd4) begin
      v = (w >> (8 * int'(off))) & 32'hFF;
      if (f3 == 3'd0 && v >= 32'h80) v = v - 32'h100;
    end else if (f3 == 3'd1 || f3 == 3'd5) begin
      v = (w >> (16 * (int'(off) / 2))) & 32'hFFFF;
      if (f3 == 3'd1 && v >= 32'h8000) v = v - 32'h10000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] m_data();
    case (m_sel)
      2'd0:    return m_load(dmem_rdata, m_f3, m_alu[1:0]);
      2'd1:    return m_alu;
      2'd2:    return m_pc + 32'd4;
      default: return m_csr;
    endcase
  endfunction

  always @(posedge clk) begin
    logic exp_we;
    if (rst) begin
      {m_valid, m_we, m_rd, m_sel, m_f3, m_alu, m_pc, m_csr} = '0;
      m_instret = 0;
    end else begin
      if (m_valid && !stall) m_instret++;
      if (flush) m_valid = 1'b0;
      else if (!stall) begin
        m_valid = in_valid; m_we = in_rd_we; m_rd = in_rd_addr; m_sel = in_wb_sel;
        m_f3 = in_funct3; m_alu = in_alu_out; m_pc = in_pc; m_csr = in_csr_data;
      end
    end
    #3;
    exp_we = m_valid && m_we && (m_rd != 5'd0) && !stall;
    chk("model_rf_we", {63'd0, rf_we}, {63'd0, exp_we});
    chk("model_wb_valid", {63'd0, wb_valid}, {63'd0, m_valid});
    chk("model_fwd_a", {63'd0, fwd_a}, {63'd0, exp_we && (dec_rs1 == m_rd)});
    chk("model_fwd_b", {63'd0, fwd_b}, {63'd0, exp_we && (dec_rs2 == m_rd)});
`ifdef AMA_RISCV_WB_INSTRET_EN
    chk("model_instret", instret, m_instret);
`else
    chk("model_instret", instret, 64'd0);
`endif
    if (m_valid) chk("model_rf_addr_d", {59'd0, rf_addr_d}, {59'd0, m_rd});
    if (exp_we) chk("model_rf_data_d", {32'd0, rf_data_d}, {32'd0, m_data()});
  end

  task automatic set_in(input logic v, input logic we, input logic [4:0] rd,
                        input logic [1:0] sel, input logic [2:0] f3,
                        input logic [31:0] alu, input logic [31:0] pc, input logic [31:0] csr);
    in_valid = v; in_rd_we = we; in_rd_addr = rd; in_wb_sel = sel;
    in_funct3 = f3; in_alu_out = alu; in_pc = pc; in_csr_data = csr;
  endtask

  // Present a bundle, let it be captured, return 2 time units into its write-back cycle.
  task automatic issue(input logic [4:0] rd, input logic [1:0] sel, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] pc, input logic [31:0] csr);
    @(negedge clk);
    set_in(1'b1, 1'b1, rd, sel, f3, alu, pc, csr);
    @(posedge clk);
    #2;
  endtask

  logic [2:0]  ld_f3  [5] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
  logic [1:0]  ld_off [5] = '{2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
  logic [31:0] ld_exp [5] = '{32'hFFFFFF88, 32'h00000088, 32'hFFFF8899, 32'h0000AABB,
                              32'h8899AABB};

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    dmem_rdata = 32'h0; dec_rs1 = 5'd0; dec_rs2 = 5'd0;
    set_in(1'b1, 1'b1, 5'd5, 2'd1, 3'd0, 32'h1234, 32'h0, 32'h0);

    @(posedge clk); #2;
    chk("rst_rf_we", {63'd0, rf_we}, 64'd0);
    chk("rst_wb_valid", {63'd0, wb_valid}, 64'd0);
    chk("rst_instret", instret, 64'd0);
    chk("rst_rf_data_d", {32'd0, rf_data_d}, 64'd0);
    chk("rst_rf_addr_d", {59'd0, rf_addr_d}, 64'd0);
    @(posedge clk); #2;
    chk("rst_hold_rf_we", {63'd0, rf_we}, 64'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #2;
    chk("first_capture_we", {63'd0, rf_we}, 64'd1);
    chk("first_capture_data", {32'd0, rf_data_d}, 64'h1234);

    dmem_rdata = 32'h8899AABB;
    for (int i = 0; i < 5; i++) begin
      issue(5'd5, 2'd0, ld_f3[i], {30'd0, ld_off[i]}, 32'h0, 32'h0);
      chk($sformatf("load_f3_%0d_off_%0d", ld_f3[i], ld_off[i]), {32'd0, rf_data_d},
          {32'd0, ld_exp[i]});
    end

    issue(5'd5, 2'd1, 3'd0, 32'h1234, 32'h0, 32'h0);
    chk("src_alu", {32'd0, rf_data_d}, 64'h1234);
    issue(5'd5, 2'd2, 3'd0, 32'h0, 32'hFFFFFFFC, 32'h0);
    chk("src_pc4_wrap", {32'd0, rf_data_d}, 64'h0);
    issue(5'd5, 2'd3, 3'd0, 32'h0, 32'h0, 32'hDEAD);
    chk("src_csr", {32'd0, rf_data_d}, 64'hDEAD);

    dec_rs1 = 5'd0;
    issue(5'd0, 2'd1, 3'd0, 32'h77, 32'h0, 32'h0);
    chk("x0_rf_we", {63'd0, rf_we}, 64'd0);
    chk("x0_fwd_a", {63'd0, fwd_a}, 64'd0);
    dec_rs1 = 5'd7; dec_rs2 = 5'd8;
    issue(5'd7, 2'd1, 3'd0, 32'h7777, 32'h0, 32'h0);
    chk("fwd_rf_we", {63'd0, rf_we}, 64'd1);
    chk("fwd_a_hit", {63'd0, fwd_a}, 64'd1);
    chk("fwd_b_miss", {63'd0, fwd_b}, 64'd0);

    // Three stalled edges on a valid write, then a single write on release.
    issue(5'd9, 2'd1, 3'd0, 32'h55, 32'h0, 32'h0);
    @(negedge clk);
    stall = 1'b1;
    set_in(1'b1, 1'b1, 5'd10, 2'd1, 3'd0, 32'hBAD, 32'h0, 32'h0);
    #1 chk("stall_rf_we", {63'd0, rf_we}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      chk("stall_hold_rf_we", {63'd0, rf_we}, 64'd0);
      chk("stall_hold_addr", {59'd0, rf_addr_d}, 64'd9);
      chk("stall_hold_valid", {63'd0, wb_valid}, 64'd1);
    end
    @(negedge clk);
    stall = 1'b0; in_valid = 1'b0;
    #1;
    chk("stall_release_we", {63'd0, rf_we}, 64'd1);
    chk("stall_release_data", {32'd0, rf_data_d}, 64'h55);
    @(posedge clk); #2;
    chk("stall_after_we", {63'd0, rf_we}, 64'd0);

    issue(5'd11, 2'd1, 3'd0, 32'h66, 32'h0, 32'h0);
    @(negedge clk);
    stall = 1'b1; flush = 1'b1;
    set_in(1'b1, 1'b1, 5'd12, 2'd1, 3'd0, 32'h67, 32'h0, 32'h0);
    @(posedge clk); #2;
    chk("flush_stall_valid", {63'd0, wb_valid}, 64'd0);
    chk("flush_stall_we", {63'd0, rf_we}, 64'd0);
    @(negedge clk);
    stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
    @(posedge clk); #2;
    chk("flush_stall_after_valid", {63'd0, wb_valid}, 64'd0);

    // Counter burst: 10 back-to-back instructions, two of them flushed on entry.
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #2;
    chk("burst_rst_instret", instret, 64'd0);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      set_in(1'b1, 1'b1, 5'(i + 1), 2'd1, 3'd0, 32'(i), 32'h0, 32'h0);
      flush = (i == 3) || (i == 7);
    end
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #2;
`ifdef AMA_RISCV_WB_INSTRET_EN
    chk("burst_instret", instret, 64'd8);
`else
    chk("burst_instret", instret, 64'd0);
`endif

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ama_riscv_writeback.md
# ama_riscv_writeback

Pipelined write-back stage of the AMA-RISCV RV32I core, sitting directly upstream of the register file. It captures the memory-stage bundle into a MEM/WB pipeline register and aligns and sign-extends load data from synchronous data memory. It selects the write-back source and drives the register file write port (we, addr_d, data_d). It also provides rs1/rs2 bypass hit flags to the decode stage, because the register file reads asynchronously and writes on the clock edge.

## Interface
- No parameters; widths fixed (XLEN 32, register address 5).
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- stall  in  1  hold stage contents; suppress write and retire
- flush  in  1  invalidate stage at next edge
- in_valid  in  1  memory-stage instruction valid
- in_rd_we  in  1  instruction writes rd
- in_rd_addr  in  5  destination register
- in_wb_sel  in  2  0 = mem, 1 = alu, 2 = pc+4, 3 = csr
- in_funct3  in  3  load width/sign (RV32I load funct3)
- in_alu_out  in  32  ALU result; bits [1:0] are the load byte offset
- in_pc  in  32  instruction PC
- in_csr_data  in  32  CSR read data
- dmem_rdata  in  32  data memory read word, valid one cycle after address (sync RAM)
- dec_rs1  in  5  decode-stage rs1
- dec_rs2  in  5  decode-stage rs2
- rf_we  out  1  register file write enable
- rf_addr_d  out  5  register file write address
- rf_data_d  out  32  register file write data
- fwd_a  out  1  rf_data_d must replace register file port A data
- fwd_b  out  1  rf_data_d must replace register file port B data
- wb_valid  out  1  stage holds a valid instruction
- instret  out  64  retired-instruction count (see Configuration)

## Operation
- Stage register update priority per edge: rst > flush > stall > capture.
  - rst: valid = 0; all stage fields = 0.
  - flush: valid = 0; other fields don't-care.
  - stall: all fields hold.
  - Otherwise: capture all in_* fields; valid = in_valid.
- rf_we = valid & rd_we & (rd_addr != 0) & !stall. x0 is never written, and each instruction writes exactly once.
- rf_addr_d = stage rd_addr, unconditionally.
- Write-data source mux:
  - mem: aligned load
  - alu: alu_out
  - pc+4: pc + 32'd4, wraps mod 2^32
  - csr: csr_data
- Load alignment, using off = stage alu_out[1:0]:
  - funct3 0 (lb) / 4 (lbu): byte at dmem_rdata[8*off +: 8], sign-extended / zero-extended.
  - funct3 1 (lh) / 5 (lhu): halfword at [16*off[1] +: 16]; off[0] is ignored; sign-/zero-extended.
  - funct3 2 (lw): full word; off is ignored.
  - funct3 3, 6, 7: raw dmem_rdata.
- fwd_a = rf_we & (dec_rs1 == rf_addr_d). fwd_b is the same using dec_rs2. Both are therefore 0 for x0.
- A flush that coincides with a stall discards the held instruction: no write, no retire.

## Timing
- Reset values:
  - rf_we, fwd_a, fwd_b, wb_valid: 0
  - rf_addr_d, rf_data_d: 0
  - instret: 0
- One-cycle latency: a bundle captured at edge N drives rf_we and rf_data_d during cycle N+1, and the register file commits it at edge N+1.
- dmem_rdata is sampled combinationally in cycle N+1. Memory must hold dmem_rdata stable while stall is high.
- All outputs except the stage register and instret are combinational from stage state and the dmem_rdata, dec_rs1 and dec_rs2 inputs.
- Retire event = valid & !stall, counted once per instruction.
- rst asserted mid-stall or mid-flush takes priority the same cycle.

## Configuration
- AMA_RISCV_WB_INSTRET_EN
  - Defined: 64-bit instret counter increments by 1 on each retire edge and wraps 2^64-1 to 0. It is cleared by rst only, not by flush.
  - Undefined: no counter flops; instret is tied to 64'd0.

## Structure
- Shared package ama_riscv_pkg holds:
  - wb_sel encodings (WB_SEL_MEM, WB_SEL_ALU, WB_SEL_PC4, WB_SEL_CSR)
  - load funct3 constants (LD_B, LD_H, LD_W, LD_BU, LD_HU)
  - RF_ADDR_W = 5, XLEN = 32
- One sub-module: ama_riscv_load_align (combinational). Inputs: dmem_rdata, funct3, offset. Output: 32-bit aligned result. It is instantiated once.

## Test plan
- Reset: hold rst 2 cycles with in_valid = 1 → rf_we = 0, wb_valid = 0, instret = 0; first capture after deassert writes the next cycle.
- Loads with dmem_rdata = 32'h8899AABB:
  - lb, off 3 → 32'hFFFFFF88
  - lbu, off 3 → 32'h00000088
  - lh, off 2 → 32'hFFFF8899
  - lhu, off 1 → 32'h0000AABB
  - lw → 32'h8899AABB
- Sources, rd = 5:
  - alu 32'h1234 → rf_data_d = 32'h1234
  - pc+4 with pc = 32'hFFFFFFFC → 32'h0
  - csr 32'hDEAD → 32'hDEAD
- x0 and forwarding:
  - rd = 0 with rd_we → rf_we = 0, fwd_a = 0 with dec_rs1 = 0.
  - rd = 7 → fwd_a = 1 with dec_rs1 = 7; fwd_b = 0 with dec_rs2 = 8.
- Stall and flush:
  - 3-cycle stall on a valid write → rf_we = 0 during stall, single write and single instret increment after release.
  - flush together with stall → instruction dropped, instret unchanged.
- Instret (macro defined): 10 valid back-to-back instructions, 2 of them flushed → instret = 8. With macro undefined → instret stays 0.
